// File: rtl/fetch_unit.sv
// Instruction fetch stage: streams sequential code-memory reads into a small
// prefetch FIFO and hands {inst, pc} to decode, flushing on branch redirects.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             nreset,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [CNT_W-1:0] inst_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = DEPTH[AW+1:0];

    logic [31:0]      r_fifo_inst [DEPTH];
    logic [31:0]      r_fifo_pc   [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_occ;
    logic [31:0]      r_fetch_pc;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic [CNT_W-1:0] r_inst_count;

    logic [AW+1:0]    w_reserved;
    logic             w_push;
    logic             w_pop;

    // Slots already promised: buffered entries plus the response still on its way.
    assign w_reserved = {1'b0, r_occ} + {{(AW+1){1'b0}}, r_inflight};

    assign mem_req    = nreset & ~redirect & (w_reserved < DEPTH_W);
    assign mem_addr   = r_fetch_pc;
    assign w_push     = nreset & ~redirect & r_inflight;
    assign inst_valid = nreset & ~redirect & (r_occ != '0);
    assign w_pop      = inst_valid & inst_ready;
    assign inst       = r_fifo_inst[r_rd_ptr];
    assign inst_pc    = r_fifo_pc[r_rd_ptr];
    assign inst_count = r_inst_count;

    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_fetch_pc   <= RESET_PC;
            r_inflight   <= 1'b0;
            r_occ        <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_inst_count <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_occ      <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (mem_req) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_inflight <= mem_req;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + AW'(1);
                r_inst_count <= r_inst_count + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // NOTE: storage and the in-flight PC carry no reset; occupancy and the
    // inflight flag decide whether their contents are ever observed.
    always_ff @(posedge clk) begin
        if (mem_req) begin
            r_inflight_pc <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= mem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table for streaming,
// stall, redirect and mid-stream reset, plus an address-wrap sequence.
module tb_fetch_unit;

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        int          exp_cnt;   // -1: not checked on this row
    } vec_t;

    logic        clk;
    logic        nreset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_count;

    logic        nreset_w;
    logic        mem_req_w;
    logic [31:0] mem_addr_w;
    logic [31:0] mem_rdata_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;
    logic [31:0] inst_w;
    logic [31:0] inst_pc_w;
    logic        inst_valid_w;
    logic        inst_ready_w;
    logic [15:0] inst_count_w;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    logic [31:0] wrap_addr [6] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] wrap_pc   [6] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
        .clk(clk), .nreset(nreset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_count(inst_count)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .CNT_W(16)) u_dut_wrap (
        .clk(clk), .nreset(nreset_w), .mem_req(mem_req_w), .mem_addr(mem_addr_w),
        .mem_rdata(mem_rdata_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
        .inst(inst_w), .inst_pc(inst_pc_w), .inst_valid(inst_valid_w),
        .inst_ready(inst_ready_w), .inst_count(inst_count_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hE000_0000 + {2'b00, a[31:2]};
    endfunction

    // Synchronous code memory models with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= word_at(mem_addr);
        if (mem_req_w) mem_rdata_w <= word_at(mem_addr_w);
    end

    function automatic vec_t v(input logic rst, input logic rd, input logic [31:0] rpc,
                               input logic rdy, input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep, input int ec);
        vec_t r;
        r.rst_n = rst; r.redir = rd; r.rpc = rpc; r.rdy = rdy;
        r.exp_req = er; r.exp_addr = ea; r.exp_valid = ev; r.exp_pc = ep; r.exp_cnt = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic build_table();
        // Streaming from reset with decode always ready.
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, -1));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 12; k++)
            vecs.push_back(v(1, 0, 0, 1, 1, 32'(4 * k), k >= 2,
                             k >= 2 ? 32'(4 * (k - 2)) : 32'h0, k >= 2 ? k - 2 : 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h30, 1, 32'h28, 10));

        // Backpressure: fill to DEPTH, then release.
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, -1));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h4, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h8, 1, 32'h0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'hC, 1, 32'h0, 0));
        for (int k = 4; k < 10; k++)
            vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 32'h0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 0, 1, 32'h0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h10, 1, 32'h4, 1));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h14, 1, 32'h8, 2));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h18, 1, 32'hC, 3));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h1C, 1, 32'h10, 4));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h20, 1, 32'h14, 5));

        // Same fill, then redirect while 8,C buffered and 0x10 in flight.
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, -1));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h4, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h8, 1, 32'h0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'hC, 1, 32'h0, 0));
        for (int k = 4; k < 10; k++)
            vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 32'h0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 0, 1, 32'h0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h10, 1, 32'h4, 1));
        vecs.push_back(v(1, 1, 32'h103, 1, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h100, 0, 0, 2));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h104, 0, 0, 2));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h108, 1, 32'h100, 2));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h10C, 1, 32'h104, 3));
        // Back-to-back redirects: only the 0x300 stream survives.
        vecs.push_back(v(1, 1, 32'h200, 1, 0, 0, 0, 0, 4));
        vecs.push_back(v(1, 1, 32'h300, 1, 0, 0, 0, 0, 4));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h300, 0, 0, 4));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h304, 0, 0, 4));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h308, 1, 32'h300, 4));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h30C, 1, 32'h304, 5));
        // Stall until full, then reset mid-stream.
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h310, 1, 32'h308, 6));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h314, 1, 32'h308, 6));
        for (int k = 0; k < 3; k++)
            vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 32'h308, 6));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 6));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h4, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'h8, 1, 32'h0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 32'hC, 1, 32'h4, 1));
    endtask

    initial begin
        nreset = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        nreset_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = '0; inst_ready_w = 1'b0;
        build_table();
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            nreset      = vecs[i].rst_n;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            inst_ready  = vecs[i].rdy;
            #1;
            check($sformatf("row%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req)
                check($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("row%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("row%0d inst_pc", i), inst_pc, vecs[i].exp_pc);
                check($sformatf("row%0d inst", i), inst, word_at(vecs[i].exp_pc));
            end
            if (vecs[i].exp_cnt >= 0)
                check($sformatf("row%0d inst_count", i), {16'b0, inst_count}, 32'(vecs[i].exp_cnt));
            @(posedge clk);
            #1;
        end

        // Address wrap on the second instance, held in reset until now.
        inst_ready_w = 1'b1;
        nreset_w     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("wrap%0d mem_req", k), {31'b0, mem_req_w}, 32'h1);
            check($sformatf("wrap%0d mem_addr", k), mem_addr_w, wrap_addr[k]);
            check($sformatf("wrap%0d inst_valid", k), {31'b0, inst_valid_w}, {31'b0, k >= 2});
            if (k >= 2) begin
                check($sformatf("wrap%0d inst_pc", k), inst_pc_w, wrap_pc[k]);
                check($sformatf("wrap%0d inst", k), inst_w, word_at(wrap_pc[k]));
            end
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage, sitting directly upstream of decode_inst.
- Drives PC-sequential addresses into the synchronous code memory (1-cycle read latency).
- Buffers returned words with their PC in a small prefetch FIFO.
- Presents them to decode over a valid/ready handshake.
- Handles branch redirects by flushing buffered and in-flight fetches and restarting at the target.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset
CNT_W, 16, width of retired-instruction debug counter

Ports:
clk  input  1  clock, all state updates on rising edge
nreset  input  1  synchronous active-low reset, sampled on rising edge of clk
mem_req  output  1  read request to code memory this cycle
mem_addr  output  32  word-aligned fetch address, valid when mem_req=1
mem_rdata  input  32  instruction word; valid exactly one cycle after a mem_req=1 cycle
redirect  input  1  branch taken; flush and restart at redirect_pc
redirect_pc  input  32  branch target; bits [1:0] ignored (treated as 0)
inst  output  32  head-of-FIFO instruction
inst_pc  output  32  address of inst
inst_valid  output  1  inst/inst_pc valid
inst_ready  input  1  decode accepts head this cycle
inst_count  output  CNT_W  number of handshakes completed (inst_valid & inst_ready), wraps

Behaviour:
- Reset (nreset=0 at edge):
  - fetch_pc <= RESET_PC, occupancy <= 0, inflight <= 0, inst_count <= 0.
  - While nreset=0: mem_req=0, inst_valid=0. inst/inst_pc are don't-care.
- State:
  - fetch_pc: next address to request.
  - inflight: 1 bit, set when a request issued last cycle.
  - inflight_pc: PC of that request.
  - FIFO of {inst, pc}, DEPTH entries, with occupancy counter 0..DEPTH.
- Issue rule: mem_req = nreset & ~redirect & (occupancy + inflight < DEPTH).
  - Uses registered occupancy only; a pop in the same cycle does not free a slot until the next cycle.
  - mem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4. Wraps 32'hFFFF_FFFC -> 0.
  - inflight <= 1 and inflight_pc <= fetch_pc; otherwise inflight <= 0.
- Response: if inflight=1 and redirect=0, push {mem_rdata, inflight_pc} at the end of the cycle. The issue rule guarantees the push never overflows.
- Output: inst_valid = (occupancy != 0) & ~redirect. Head entry drives inst/inst_pc combinationally.
  - Pop when inst_valid & inst_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - inst_count increments on each pop.
- Redirect (redirect=1 at edge):
  - occupancy <= 0 and inflight <= 0.
  - The response arriving this cycle is discarded and nothing is pushed.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - mem_req=0 during the redirect cycle; first target fetch issues the following cycle.
  - No pop occurs and inst_count does not increment in the redirect cycle.
- Back-to-back redirects: each redirect cycle repeats the flush. The last one wins.
- Latency: first target instruction is valid 2 cycles after the request issues. From reset release or redirect deassertion, inst_valid rises on the 2nd rising edge.
- Steady state with inst_ready=1: one instruction per cycle, no bubbles.
- Stall: with inst_ready=0 the FIFO fills to DEPTH, then mem_req drops. On resume, throughput recovers without loss or duplication.
- Reset mid-operation: all buffered and in-flight data are dropped. No push occurs on the reset edge.
- Memory word order is preserved exactly: each inst_pc equals the address that produced inst.

Test Plan:
- Reset release, RESET_PC=0, memory word i = 32'hE000_0000+i, inst_ready=1 -> mem_addr 0,4,8… on consecutive cycles. inst_valid rises on the 2nd edge with inst=E0000000/pc 0, then one per cycle. inst_count=10 after 10 accepts.
- Backpressure: hold inst_ready=0 for 8 cycles after the first valid -> occupancy reaches 4, mem_req=0, fetch_pc=0x10. Release -> pcs 0,4,8,C,10,14 with no gaps or duplicates.
- Redirect while FIFO holds pcs 8,C and a request for 0x10 is in flight; redirect_pc=0x103 -> 0x10 response is dropped, mem_req=0 that cycle, next mem_addr=0x100, next inst_pc seen=0x100.
- Two consecutive redirect cycles (targets 0x200 then 0x300) -> only 0x300 stream appears, first valid 2 edges after the second redirect.
- Wrap: RESET_PC=32'hFFFF_FFF8 -> inst_pc sequence FFFFFFF8, FFFFFFFC, 0, 4.
- Assert nreset=0 mid-stream with FIFO full -> next cycle mem_req=0, inst_valid=0, inst_count=0. After release, restart from RESET_PC.
